// File: rtl/alu_seq_unit_if.sv
// ---------------------------------------------------------------------------
// alu_seq_unit_if
// Bus-side handshake bundle for alu_seq_unit.
//   din    : operand from the bus
//   ai/bi  : load din into operand register A / B
//   op     : operation code, sampled when start is accepted
//   start  : operation request
//   busy   : multi-cycle operation in progress
//   done   : one-cycle pulse, result/flags just updated
//   result : registered result
//   flags  : registered {C, V, N, Z}
// master = operand source / result sink, slave = the ALU.
// ---------------------------------------------------------------------------
interface alu_seq_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             ai;
    logic             bi;
    logic [2:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output din, ai, bi, op, start,
        input  busy, done, result, flags
    );

    modport slave (
        input  din, ai, bi, op, start,
        output busy, done, result, flags
    );
endinterface

// File: rtl/alu_seq_unit.sv
// ---------------------------------------------------------------------------
// alu_seq_unit
// Two-operand ALU with a start/busy/done handshake. ADD/SUB/AND/OR/XOR and
// zero-amount shifts complete at the accepting edge; non-zero shifts run one
// bit per cycle and MUL runs WIDTH shift-add iterations.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : alu_seq_unit_if.slave (din, ai, bi, op, start -> busy, done,
//           result, flags)
// ---------------------------------------------------------------------------
module alu_seq_unit #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    alu_seq_unit_if.slave bus
);
    // Counter must hold both WIDTH (MUL) and the largest shift amount.
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   res_q;
    logic [3:0]         flags_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   work_q;   // shift working value, or multiplicand
    logic [2*WIDTH-1:0] acc_q;    // {partial product, remaining multiplier bits}
    logic [CW-1:0]      cnt_q;
    logic               dir_q;    // 1 = shift right

    logic [SW-1:0]      amt;
    logic [WIDTH-1:0]   alu_res_d;
    logic [3:0]         alu_flags_d;
    logic [WIDTH-1:0]   sh_work_d;
    logic               sh_c_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_d;

    assign amt = b_q[SW-1:0];

    // Single-cycle datapath, also covers zero-amount shifts (A passes through).
    always_comb begin
        logic [WIDTH-1:0] b_op;
        logic [WIDTH:0]   sum;
        logic             c, v;
        b_op      = (bus.op == OP_SUB) ? ~b_q : b_q;
        sum       = {1'b0, a_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, (bus.op == OP_SUB)};
        c         = 1'b0;
        v         = 1'b0;
        alu_res_d = '0;
        case (bus.op)
            OP_ADD, OP_SUB: begin
                alu_res_d = sum[WIDTH-1:0];
                c         = sum[WIDTH];
                // Overflow: operands agree in sign, result disagrees.
                v         = (a_q[WIDTH-1] == b_op[WIDTH-1]) &&
                            (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:         alu_res_d = a_q & b_q;
            OP_OR:          alu_res_d = a_q | b_q;
            OP_XOR:         alu_res_d = a_q ^ b_q;
            OP_SHL, OP_SHR: alu_res_d = a_q;
            default:        alu_res_d = '0;
        endcase
        alu_flags_d = {c, v, alu_res_d[WIDTH-1], (alu_res_d == '0)};
    end

    // One shift step; the bit leaving the register becomes the carry.
    always_comb begin
        sh_work_d = dir_q ? (work_q >> 1) : (work_q << 1);
        sh_c_d    = dir_q ? work_q[0] : work_q[WIDTH-1];
    end

    // One shift-add step: add multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole accumulator right.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, work_q} : {(WIDTH+1){1'b0}});
        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            work_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Loads land even on the accepting edge; the operation below
            // already captured the old A/B values.
            if (!busy_q) begin
                if (bus.ai) a_q <= bus.din;
                if (bus.bi) b_q <= bus.din;
            end
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MUL) begin
                            work_q  <= a_q;
                            acc_q   <= {{WIDTH{1'b0}}, b_q};
                            cnt_q   <= CW'(WIDTH);
                            busy_q  <= 1'b1;
                            state_q <= MUL;
                        end else if ((bus.op == OP_SHL || bus.op == OP_SHR) &&
                                     (amt != '0)) begin
                            work_q  <= a_q;
                            dir_q   <= (bus.op == OP_SHR);
                            cnt_q   <= {1'b0, amt};
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end else begin
                            res_q   <= alu_res_d;
                            flags_q <= alu_flags_d;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= sh_work_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        res_q   <= sh_work_d;
                        flags_q <= {sh_c_d, 1'b0, sh_work_d[WIDTH-1], (sh_work_d == '0)};
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        res_q   <= acc_d[WIDTH-1:0];
                        flags_q <= {(acc_d[2*WIDTH-1:WIDTH] != '0), 1'b0,
                                    acc_d[WIDTH-1], (acc_d[WIDTH-1:0] == '0)};
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_unit
// Directed checks with hand-derived values followed by random operations
// checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq_unit;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_unit_if #(.WIDTH(W)) bus();
    alu_seq_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {flags C,V,N,Z, result} from plain integer arithmetic.
    function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] o);
        int ua = a, ub = b, sa = $signed(a), sb = $signed(b);
        int amt = ub % W;
        int r = 0;
        logic c = 1'b0, v = 1'b0;
        logic [W-1:0] res;
        case (o)
            3'd0: begin r = ua + ub; c = (r >= 256); v = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin r = ua - ub; c = (ua >= ub); v = (sa - sb > 127) || (sa - sb < -128); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua << amt; c = (amt != 0) && (((ua >> (W - amt)) & 1) == 1); end
            3'd6: begin r = ua >> amt; c = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1); end
            default: begin r = ua * ub; c = (r >= 256); end
        endcase
        res = r[W-1:0];
        return {c, v, res[W-1], (res == 0), res};
    endfunction

    function automatic int lat(input logic [W-1:0] b, input logic [2:0] o);
        int amt = b % W;
        if (o == 3'd7) return W + 1;
        if ((o == 3'd5 || o == 3'd6) && amt != 0) return amt + 1;
        return 1;
    endfunction

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.din = a; bus.ai = 1'b1; step(); bus.ai = 1'b0;
        bus.din = b; bus.bi = 1'b1; step(); bus.bi = 1'b0;
        bus.din = '0;
    endtask

    // Waits for done (bounded), checking busy/hold/exclusivity on the way.
    task automatic wait_done(input string tag, input logic [W-1:0] pr, input logic [3:0] pf,
                             output int cyc);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_hold"}, {20'd0, bus.flags, bus.result}, {20'd0, pf, pr});
            step();
            cyc++;
        end
    endtask

    // Issues start in the current cycle and checks the completed operation.
    task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] er,
                       input logic [3:0] ef, input int el);
        logic [W-1:0] pr;
        logic [3:0]   pf;
        int           cyc;
        pr = bus.result; pf = bus.flags;
        bus.op = o; bus.start = 1'b1; step(); bus.start = 1'b0;
        wait_done(tag, pr, pf, cyc);
        chk({tag, "_lat"},    32'(cyc), 32'(el));
        chk({tag, "_excl"},   32'(bus.busy & bus.done), 32'd0);
        chk({tag, "_result"}, 32'(bus.result), 32'(er));
        chk({tag, "_flags"},  32'(bus.flags), 32'(ef));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0]   ro;
        logic [W+3:0] e;
        int           cyc;

        reset = 1'b1;
        bus.din = '0; bus.ai = 1'b0; bus.bi = 1'b0; bus.op = '0; bus.start = 1'b0;
        step(); step();
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_done",   32'(bus.done),   32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_flags",  32'(bus.flags),  32'd0);
        reset = 1'b0;
        step();

        // Directed arithmetic/logic
        load(8'h7F, 8'h01); run("add_ovf",  3'd0, 8'h80, 4'b0110, 1);
        step(); chk("done_pulse", 32'(bus.done), 32'd0);
        load(8'hFF, 8'h01); run("add_cz",   3'd0, 8'h00, 4'b1001, 1);
        load(8'h05, 8'h05); run("sub_eq",   3'd1, 8'h00, 4'b1001, 1);
        load(8'h03, 8'h05); run("sub_brw",  3'd1, 8'hFE, 4'b0010, 1);
        load(8'hF0, 8'h3C); run("and",      3'd2, 8'h30, 4'b0000, 1);
        run("or",  3'd3, 8'hFC, 4'b0010, 1);
        run("xor", 3'd4, 8'hCC, 4'b0010, 1);

        // Shifts
        load(8'h81, 8'd3); run("shl3",  3'd5, 8'h08, 4'b0000, 4);
        load(8'h81, 8'd1); run("shr1",  3'd6, 8'h40, 4'b1000, 2);
        load(8'h81, 8'd8); run("shl0",  3'd5, 8'h81, 4'b0010, 1);

        // Multiply
        load(8'h10, 8'h11); run("mul_hi", 3'd7, 8'h10, 4'b1000, 9);
        load(8'h0F, 8'h0F); run("mul_lo", 3'd7, 8'hE1, 4'b0010, 9);

        // start and ai while busy are ignored; start in done cycle accepted
        load(8'h10, 8'h11);
        bus.op = 3'd7; bus.start = 1'b1; step(); bus.start = 1'b0;
        step();
        bus.op = 3'd0; bus.start = 1'b1; bus.ai = 1'b1; bus.din = 8'h55; step();
        bus.start = 1'b0; bus.ai = 1'b0; bus.din = '0;
        wait_done("busy_ign", 8'hE1, 4'b0010, cyc);
        cyc += 2;
        chk("busy_ign_lat",    32'(cyc), 32'd9);
        chk("busy_ign_result", 32'(bus.result), 32'h10);
        chk("busy_ign_flags",  32'(bus.flags), 32'b1000);
        run("b2b_add", 3'd0, 8'h21, 4'b0000, 1);

        // Reset in the middle of a multiply
        load(8'h10, 8'h11);
        bus.op = 3'd7; bus.start = 1'b1; step(); bus.start = 1'b0;
        step(); step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("mrst_busy",   32'(bus.busy),   32'd0);
        chk("mrst_done",   32'(bus.done),   32'd0);
        chk("mrst_result", 32'(bus.result), 32'd0);
        chk("mrst_flags",  32'(bus.flags),  32'd0);
        for (int i = 0; i < W + 4; i++) begin
            chk("mrst_nodone", 32'(bus.done), 32'd0);
            step();
        end
        run("mrst_ab_zero", 3'd0, 8'h00, 4'b0001, 1);

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            ro = 3'($urandom_range(0, 7));
            e  = model(ra, rb, ro);
            load(ra, rb);
            run($sformatf("rnd%0d_op%0d", i, ro), ro, e[W-1:0], e[W+3:W], lat(rb, ro));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
